// File: rtl/bus_requester_pkg.sv
// rtl/bus_requester_pkg.sv - shared encodings and constants for the bus requester
package bus_requester_pkg;

    // Word-count field width, shared with the arbiter and the uart data path.
    localparam int BUS_WORD_CNT_W = 4;

    // Active levels of the arbiter handshake lines.
    localparam logic REQ_ENABLE   = 1'b1;
    localparam logic FREE_ENABLE  = 1'b1;
    localparam logic GRANT_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        REQ_STATE_IDLE      = 3'd0,
        REQ_STATE_REQ       = 3'd1,
        REQ_STATE_XFER      = 3'd2,
        REQ_STATE_RELEASE   = 3'd3,
        REQ_STATE_WAIT_DROP = 3'd4
    } req_state_e;

endpackage

// File: rtl/bus_requester_if.sv
// rtl/bus_requester_if.sv - requester/arbiter handshake bundle
// Signals: bus_req (request), bus_grant (grant), bus_word_number (word count,
// valid while granted), bus_free (one-cycle release pulse).
// master: requester side; slave: arbiter side.
interface bus_requester_if #(
    parameter int CNT_W = 4
) ();
    logic             bus_req;
    logic             bus_grant;
    logic [CNT_W-1:0] bus_word_number;
    logic             bus_free;

    modport master (output bus_req, output bus_free,
                    input  bus_grant, input bus_word_number);
    modport slave  (input  bus_req, input bus_free,
                    output bus_grant, output bus_word_number);
endinterface

// File: rtl/bus_requester_skid.sv
// rtl/bus_requester_skid.sv - one-entry valid/ready register between client and tx path
// Ports: clk, resetn (async active-low), flush (drop held word), accept_en
// (top-level gate on taking new words), cli_data/cli_valid/cli_ready (client
// side), tx_data/tx_valid/tx_ready (uart side).
module bus_requester_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              accept_en,
    input  logic [DATA_W-1:0] cli_data,
    input  logic              cli_valid,
    output logic              cli_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    // The register can take a word when empty or emptying this cycle.
    assign cli_ready = accept_en && (!tx_valid || tx_ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (flush) begin
            tx_valid <= 1'b0;
        end else if (cli_valid && cli_ready) begin
            tx_valid <= 1'b1;
            tx_data  <= cli_data;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bus_requester.sv
// rtl/bus_requester.sv - per-client bus master: request, forward granted word count, release
// Ports: clk, resetn (async active-low), start/busy/done (client control),
// bus (bus_requester_if.master toward the arbiter), cli_* (client words in),
// tx_* (words out to the uart path), timeout_err (sticky, only with
// BUS_REQUESTER_GRANT_TIMEOUT_EN defined).
// Optional feature macro: BUS_REQUESTER_GRANT_TIMEOUT_EN.
module bus_requester
    import bus_requester_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = BUS_WORD_CNT_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    bus_requester_if.master   bus,
    input  logic [DATA_W-1:0] cli_data,
    input  logic              cli_valid,
    output logic              cli_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
`ifdef BUS_REQUESTER_GRANT_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    req_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             grant_on;
    logic             tx_hs;
    logic             last_word;
    logic             abort;
    logic             room;
    logic             accept_en;
    logic             timeout_hit;

    assign grant_on  = (bus.bus_grant == GRANT_ENABLE);
    assign tx_hs     = tx_valid && tx_ready;
    assign last_word = tx_hs && (cnt == CNT_W'(1));
    assign abort     = (state == REQ_STATE_XFER) && !grant_on;
    // cnt includes the word already held, so a full register needs cnt >= 2
    // before another word may be taken.
    assign room      = tx_valid ? (cnt > CNT_W'(1)) : (cnt != '0);
    assign accept_en = (state == REQ_STATE_XFER) && grant_on && room;

`ifdef BUS_REQUESTER_GRANT_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;

    assign timeout_hit = (state == REQ_STATE_REQ) && !grant_on && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt    <= (state == REQ_STATE_REQ && !timeout_hit) ? wait_cnt + 8'd1 : 8'd0;
            timeout_err <= timeout_err | timeout_hit;
        end
    end
`else
    // REQ never times out in this build.
    assign timeout_hit = 1'b0 & (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= REQ_STATE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            REQ_STATE_IDLE:
                // done high means we just left WAIT_DROP; that start is dropped.
                if (start && !done) state_nxt = REQ_STATE_REQ;
            REQ_STATE_REQ:
                if (grant_on)
                    state_nxt = (bus.bus_word_number == '0) ? REQ_STATE_RELEASE : REQ_STATE_XFER;
                else if (timeout_hit)
                    state_nxt = REQ_STATE_IDLE;
            REQ_STATE_XFER:
                if (!grant_on)      state_nxt = REQ_STATE_IDLE;
                else if (last_word) state_nxt = REQ_STATE_RELEASE;
            REQ_STATE_RELEASE:
                state_nxt = REQ_STATE_WAIT_DROP;
            REQ_STATE_WAIT_DROP:
                if (!grant_on) state_nxt = REQ_STATE_IDLE;
            default:
                state_nxt = REQ_STATE_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != REQ_STATE_IDLE);
        bus.bus_req  = (state == REQ_STATE_REQ) ? REQ_ENABLE : !REQ_ENABLE;
        bus.bus_free = (state == REQ_STATE_RELEASE) ? FREE_ENABLE : !FREE_ENABLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == REQ_STATE_WAIT_DROP) && !grant_on;
            if (state == REQ_STATE_REQ && grant_on)
                cnt <= bus.bus_word_number;
            else if (abort)
                cnt <= '0;
            else if (state == REQ_STATE_XFER && tx_hs)
                cnt <= cnt - CNT_W'(1);
        end
    end

    bus_requester_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (abort),
        .accept_en (accept_en),
        .cli_data  (cli_data),
        .cli_valid (cli_valid),
        .cli_ready (cli_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

endmodule

// File: tb/tb_bus_requester.sv
// tb/tb_bus_requester.sv - directed self-checking bench for bus_requester
module tb_bus_requester;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [31:0] cli_data = 32'h100;
    logic        cli_valid = 1'b1;
    logic        cli_ready;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
`ifdef BUS_REQUESTER_GRANT_TIMEOUT_EN
    logic        timeout_err;
`endif

    bus_requester_if #(.CNT_W(4)) bif ();

    bus_requester #(.DATA_W(32), .CNT_W(4), .TIMEOUT(10)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .bus       (bif),
        .cli_data  (cli_data),
        .cli_valid (cli_valid),
        .cli_ready (cli_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
`ifdef BUS_REQUESTER_GRANT_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_tx, n_cli, n_free, n_done, cyc, last_tx_cyc, free_cyc;
    logic [31:0] tx_log[$];

    task automatic clear_counts();
        n_tx = 0; n_cli = 0; n_free = 0; n_done = 0;
        last_tx_cyc = -10; free_cyc = -10;
        tx_log.delete();
    endtask

    // Samples handshakes just before the edge, advances one clock, and
    // returns 1 time unit after the edge.
    task automatic tick();
        logic hs_cli;
        #1;
        hs_cli = cli_valid && cli_ready;
        if (hs_cli) n_cli++;
        if (tx_valid && tx_ready) begin
            n_tx++;
            tx_log.push_back(tx_data);
            last_tx_cyc = cyc;
        end
        if (bif.bus_free) begin n_free++; free_cyc = cyc; end
        if (done) n_done++;
        @(posedge clk);
        #1;
        cyc++;
        if (hs_cli) cli_data = cli_data + 32'd1;
    endtask

    task automatic do_transfer(input logic [3:0] wn, output bit ok);
        start = 1'b1; tick(); start = 1'b0;
        bif.bus_grant = 1'b1; bif.bus_word_number = wn;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bif.bus_free) begin ok = 1'b1; break; end
        end
        tick();
        bif.bus_grant = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; tx_ready = 1'b1; cli_valid = 1'b1;
        bif.bus_grant = 1'b0; bif.bus_word_number = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got=%0b exp=0", bif.bus_req); end
        checks++; if (bif.bus_free !== 1'b0) begin failures++; $display("FAIL reset_bus_free got=%0b exp=0", bif.bus_free); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_data !== 32'h0) begin failures++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
        checks++; if (cli_ready !== 1'b0) begin failures++; $display("FAIL reset_cli_ready got=%0b exp=0", cli_ready); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] d0;
        bit ok;
        clear_counts();
        d0 = cli_data;
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (bif.bus_req !== 1'b1) begin failures++; $display("FAIL basic_req_up got=%0b exp=1", bif.bus_req); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        tick(); tick(); tick();
        checks++; if (bif.bus_req !== 1'b1) begin failures++; $display("FAIL basic_req_hold got=%0b exp=1", bif.bus_req); end
        bif.bus_grant = 1'b1; bif.bus_word_number = 4'd4;
        tick();
        checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%0b exp=0", bif.bus_req); end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bif.bus_free) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL basic_free_seen got=0 exp=1"); end
        tick();
        checks++; if (bif.bus_free !== 1'b0) begin failures++; $display("FAIL basic_free_one_cycle got=%0b exp=0", bif.bus_free); end
        bif.bus_grant = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%0b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%0b exp=0", done); end
        checks++; if (n_tx !== 4) begin failures++; $display("FAIL basic_tx_count got=%0d exp=4", n_tx); end
        checks++; if (n_cli !== 4) begin failures++; $display("FAIL basic_cli_count got=%0d exp=4", n_cli); end
        checks++; if (n_free !== 1) begin failures++; $display("FAIL basic_free_count got=%0d exp=1", n_free); end
        checks++; if (free_cyc !== last_tx_cyc + 1) begin failures++; $display("FAIL basic_free_timing got=%0d exp=%0d", free_cyc, last_tx_cyc + 1); end
        for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
            checks++; if (tx_log[i] !== d0 + 32'(i)) begin failures++; $display("FAIL basic_word%0d got=%0h exp=%0h", i, tx_log[i], d0 + 32'(i)); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d0;
        bit ok, stalled;
        clear_counts();
        d0 = cli_data;
        stalled = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        bif.bus_grant = 1'b1; bif.bus_word_number = 4'd4;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!stalled && tx_valid && tx_data == d0 + 32'd1) begin
                stalled = 1'b1;
                tx_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    checks++; if (tx_data !== d0 + 32'd1) begin failures++; $display("FAIL stall_data_c%0d got=%0h exp=%0h", k, tx_data, d0 + 32'd1); end
                    checks++; if (cli_ready !== 1'b0) begin failures++; $display("FAIL stall_cli_ready_c%0d got=%0b exp=0", k, cli_ready); end
                end
                tx_ready = 1'b1;
            end
            tick();
            if (bif.bus_free) begin ok = 1'b1; break; end
        end
        checks++; if (!(ok && stalled)) begin failures++; $display("FAIL stall_reached got=%0b%0b exp=11", ok, stalled); end
        tick();
        bif.bus_grant = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%0b exp=1", done); end
        tick();
        checks++; if (n_tx !== 4) begin failures++; $display("FAIL stall_tx_count got=%0d exp=4", n_tx); end
        for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
            checks++; if (tx_log[i] !== d0 + 32'(i)) begin failures++; $display("FAIL stall_word%0d got=%0h exp=%0h", i, tx_log[i], d0 + 32'(i)); end
        end
    endtask

    task automatic test_zero();
        clear_counts();
        start = 1'b1; tick(); start = 1'b0;
        bif.bus_grant = 1'b1; bif.bus_word_number = 4'd0;
        tick();
        checks++; if (bif.bus_free !== 1'b1) begin failures++; $display("FAIL zero_free got=%0b exp=1", bif.bus_free); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL zero_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (cli_ready !== 1'b0) begin failures++; $display("FAIL zero_cli_ready got=%0b exp=0", cli_ready); end
        tick();
        checks++; if (bif.bus_free !== 1'b0) begin failures++; $display("FAIL zero_free_one got=%0b exp=0", bif.bus_free); end
        bif.bus_grant = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%0b exp=1", done); end
        tick();
        checks++; if (n_tx !== 0) begin failures++; $display("FAIL zero_tx_count got=%0d exp=0", n_tx); end
    endtask

    task automatic test_abort();
        bit ok;
        clear_counts();
        start = 1'b1; tick(); start = 1'b0;
        bif.bus_grant = 1'b1; bif.bus_word_number = 4'd4;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (n_tx >= 2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL abort_two_words got=%0d exp=2", n_tx); end
        bif.bus_grant = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL abort_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL abort_bus_req got=%0b exp=0", bif.bus_req); end
        repeat (4) tick();
        checks++; if (n_free !== 0) begin failures++; $display("FAIL abort_no_free got=%0d exp=0", n_free); end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_counts();
        start = 1'b1; tick(); start = 1'b0;
        bif.bus_grant = 1'b1; bif.bus_word_number = 4'd2;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bif.bus_free) begin ok = 1'b1; break; end
        end
        tick();
        bif.bus_grant = 1'b0;
        tick();
        checks++; if (done !== 1'b1 || !ok) begin failures++; $display("FAIL b2b_done got=%0b exp=1", done); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_start_on_done_busy got=%0b exp=0", busy); end
        checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL b2b_start_on_done_req got=%0b exp=0", bif.bus_req); end
        do_transfer(4'd1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_second_free got=0 exp=1"); end
        checks++; if (n_tx !== 3) begin failures++; $display("FAIL b2b_tx_count got=%0d exp=3", n_tx); end
        checks++; if (n_done !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_counts();
        start = 1'b1; tick(); start = 1'b0;
        bif.bus_grant = 1'b1; bif.bus_word_number = 4'd4;
        tick(); tick();
        #2 resetn = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_data !== 32'h0) begin failures++; $display("FAIL rst_mid_tx_data got=%0h exp=0", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
        checks++; if (cli_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_cli_ready got=%0b exp=0", cli_ready); end
        bif.bus_grant = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        clear_counts();
        do_transfer(4'd3, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_mid_free got=0 exp=1"); end
        checks++; if (n_tx !== 3) begin failures++; $display("FAIL rst_mid_tx_count got=%0d exp=3", n_tx); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL rst_mid_done_count got=%0d exp=1", n_done); end
    endtask

`ifdef BUS_REQUESTER_GRANT_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles;
        clear_counts();
        start = 1'b1; tick(); start = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            if (!bif.bus_req) break;
            req_cycles++;
            tick();
        end
        checks++; if (req_cycles !== 10) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=10", req_cycles); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_set got=%0b exp=1", timeout_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%0b exp=0", busy); end
        repeat (3) tick();
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_sticky got=%0b exp=1", timeout_err); end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL timeout_no_done got=%0d exp=0", n_done); end
    endtask
`endif

    initial begin
        cyc = 0;
        bif.bus_grant = 1'b0;
        bif.bus_word_number = '0;
        clear_counts();
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef BUS_REQUESTER_GRANT_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
